// File: rtl/ascon_sbox_lane_scheduler.sv
// Ascon substitution-layer scheduler.
// Walks the 64 bit-sliced columns of a 320-bit state through a shared S-box
// LUT, LANES columns per cycle, and returns the substituted state over a
// valid/ready handshake. The LUT ports are idle (zero) whenever no layer is
// being computed, so other masters can share them.
module ascon_sbox_lane_scheduler #(
  parameter int LANES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4:0][63:0]       state_i,
  output logic                   lut_en_o,
  output logic [LANES-1:0][4:0]  lut_addr_o,
  input  logic [LANES-1:0][4:0]  lut_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4:0][63:0]       state_o,
  output logic                   busy_o
);

  localparam int NGROUPS = 64 / LANES;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  // Only power-of-two lane counts divide the 64 columns into whole groups.
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("ascon_sbox_lane_scheduler: LANES must be 1, 2, 4, 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0][63:0]  src_q;
  logic [4:0][63:0]  res_q;
  logic              accept;
  logic              last_group;
  logic [LANES-1:0][5:0] col;

  assign accept     = (state_q == ST_IDLE) && in_valid_i;
  assign last_group = (cnt_q == CNT_W'(NGROUPS - 1));
  assign state_o    = res_q;

  // Column served by each lane in the current group: j = group*LANES + lane.
  always_comb begin
    col = '0;
    for (int k = 0; k < LANES; k++) begin
      col[k] = 6'(int'(cnt_q) * LANES + k);
    end
  end

  // Next-state and handshake/status outputs, all decoded from the FSM state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
    state_d     = state_q;
    in_ready_o  = 1'b0;
    lut_en_o    = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        lut_en_o = 1'b1;
        busy_o   = 1'b1;
        if (last_group) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LUT addresses: one column per lane, x0 bit as MSB; zero outside RUN.
  always_comb begin
    lut_addr_o = '0;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < LANES; k++) begin
        lut_addr_o[k] = {src_q[0][col[k]], src_q[1][col[k]], src_q[2][col[k]],
                         src_q[3][col[k]], src_q[4][col[k]]};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Group counter: cleared on accept, advances once per RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      cnt_q <= last_group ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Source register: captures the incoming state on the accept handshake.
  always_ff @(posedge clk_i) begin
    // NOTE: pure datapath storage is left without reset; it is always written before it is read, so a reset would only cost area.
    if (accept) src_q <= state_i;
  end

  // Result register: scatters each lane's LUT data back into its column.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (state_q == ST_RUN) begin
      for (int k = 0; k < LANES; k++) begin
        for (int i = 0; i < 5; i++) begin
          res_q[i][col[k]] <= lut_data_i[k][4-i];
        end
      end
    end
  end

endmodule
